// File: rtl/biquad_ctrl.sv
// Coefficient shadow/live bank manager and reset sequencer for the sigma-delta biquad.
// Optional watchdog enabled by defining BIQUAD_CTRL_WATCHDOG_EN (adds the wd_trip port).
module biquad_ctrl #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned WD_LIMIT     = 1024,
  parameter int unsigned WD_WIDTH     = 16
) (
  input  logic        filter_clock,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        addr_err,
  input  logic        commit_req,
  output logic        commit_ack,
  output logic        busy,
  input  logic        filt_mainOut,
  output logic        filt_reset,
  output logic [31:0] ffGain1,
  output logic [31:0] ffGain2,
  output logic [31:0] ffGain3,
  output logic [31:0] ffGain4,
  output logic [31:0] ffGain5,
  output logic [31:0] fbGain1,
  output logic [31:0] fbGain2,
  output logic [31:0] fbGain3,
  output logic [31:0] fbGain4,
  output logic [31:0] delay1_ivalue,
  output logic [31:0] delay2_ivalue,
  output logic [31:0] delay3_ivalue,
  output logic [31:0] delay4_ivalue,
  output logic [31:0] sdDelay_ivalue
`ifdef BIQUAD_CTRL_WATCHDOG_EN
  ,
  output logic        wd_trip
`endif
);

  if (RESET_CYCLES < 1 || RESET_CYCLES > 255) begin : g_bad_reset_cycles
    $error("biquad_ctrl: RESET_CYCLES must be in 1..255");
  end
  if (WD_LIMIT < 2 || WD_LIMIT >= (64'd1 << WD_WIDTH)) begin : g_bad_wd_limit
    $error("biquad_ctrl: WD_LIMIT must be >= 2 and < 2**WD_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_HOLD,
    S_RUN
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  hold_cnt;
  logic        pending;
  logic        from_commit;
  logic        wr_accept;
  logic        wd_hit;
  logic [31:0] shadow [0:13];
  logic [31:0] live   [0:13];

  assign wr_ready  = (state != S_APPLY);
  assign busy      = (state == S_APPLY) || (state == S_HOLD);
  assign wr_accept = wr_valid && wr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (commit_req) state_nxt = S_APPLY;
      S_APPLY: state_nxt = S_HOLD;
      S_HOLD:  if (hold_cnt == '0) state_nxt = S_RUN;
      S_RUN: begin
        // Commit wins over a coincident watchdog trip.
        if (commit_req || pending) state_nxt = S_APPLY;
        else if (wd_hit)           state_nxt = S_HOLD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge filter_clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      pending     <= 1'b0;
      from_commit <= 1'b0;
      commit_ack  <= 1'b0;
      addr_err    <= 1'b0;
      filt_reset  <= 1'b1;
      for (int unsigned i = 0; i < 14; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
    end else begin
      state <= state_nxt;

      if (state_nxt == S_HOLD && state != S_HOLD)
        hold_cnt <= 8'(RESET_CYCLES - 1);
      else if (state == S_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 8'd1;

      if (state == S_RUN)
        pending <= 1'b0;
      else if ((state == S_APPLY || state == S_HOLD) && commit_req)
        pending <= 1'b1;

      // Only HOLD periods that follow an APPLY end with an acknowledge.
      if (state == S_APPLY)
        from_commit <= 1'b1;
      else if (state == S_RUN && state_nxt == S_HOLD)
        from_commit <= 1'b0;

      commit_ack <= (state == S_HOLD) && (state_nxt == S_RUN) && from_commit;
      filt_reset <= (state_nxt != S_RUN);
      addr_err   <= wr_accept && (wr_addr > 4'd13);

      if (wr_accept && wr_addr <= 4'd13)
        shadow[wr_addr] <= wr_data;

      if (state == S_APPLY)
        for (int unsigned i = 0; i < 14; i++)
          live[i] <= shadow[i];
    end
  end

`ifdef BIQUAD_CTRL_WATCHDOG_EN
  logic [WD_WIDTH-1:0] wd_cnt;
  logic                main_q;
  logic                main_chg;

  assign main_chg = (filt_mainOut != main_q);
  assign wd_hit   = (state == S_RUN) && !main_chg && (wd_cnt == WD_WIDTH'(WD_LIMIT - 1));

  always_ff @(posedge filter_clock or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      main_q  <= 1'b0;
      wd_trip <= 1'b0;
    end else begin
      main_q <= filt_mainOut;
      if (state != S_RUN || main_chg || wd_hit)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;

      if (state == S_APPLY)
        wd_trip <= 1'b0;
      else if (state == S_RUN && state_nxt == S_HOLD)
        wd_trip <= 1'b1;
    end
  end
`else
  logic unused_mainout;
  assign unused_mainout = filt_mainOut;
  assign wd_hit         = 1'b0;
`endif

  assign ffGain1        = live[0];
  assign ffGain2        = live[1];
  assign ffGain3        = live[2];
  assign ffGain4        = live[3];
  assign ffGain5        = live[4];
  assign fbGain1        = live[5];
  assign fbGain2        = live[6];
  assign fbGain3        = live[7];
  assign fbGain4        = live[8];
  assign delay1_ivalue  = live[9];
  assign delay2_ivalue  = live[10];
  assign delay3_ivalue  = live[11];
  assign delay4_ivalue  = live[12];
  assign sdDelay_ivalue = live[13];

endmodule
